// File: rtl/upe_pkg.sv
// upe_pkg: sequencer state encoding and default array geometry shared by pe_array_ctrl and its bench.
package upe_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} pe_ctrl_state_t;
    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-stage 1-bit shift register; din appears on dout exactly DEPTH cycles later.
module valid_delay_line #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else sr <= DEPTH'({sr, din});
    end
    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: weight-load / activation-stream sequencer for a ROWS x COLS weight-stationary PE array.
// Define PE_CTRL_PERF_EN to build the saturating bubble counter on stall_cnt.
module pe_array_ctrl
    import upe_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int VEC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VEC_W-1:0] num_vec,
    output logic             busy,
    output logic             done,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [ROWS-1:0]  pe_load_en,
    output logic             pe_compute,
    output logic             pe_zero_act,
    output logic             res_valid,
    output logic [31:0]      stall_cnt
);
    localparam int LAT = ROWS + COLS - 1;
    localparam int RW  = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int DW  = $clog2(LAT + 1);
    pe_ctrl_state_t state, state_n;
    logic [RW-1:0]    row;
    logic [VEC_W-1:0] nv, issued;
    logic [DW-1:0]    dcnt;
    logic             w_acc, issue, job_start;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            row    <= '0;
            nv     <= '0;
            issued <= '0;
            dcnt   <= '0;
        end else begin
            state <= state_n;
            if (job_start) begin
                nv     <= num_vec;
                row    <= '0;
                issued <= '0;
                dcnt   <= '0;
            end
            if (w_acc) row <= row + 1'b1;
            if (issue) issued <= issued + 1'b1;
            if (state == DRAIN) dcnt <= dcnt + 1'b1;
        end
    end
    always_comb begin
        job_start   = state == IDLE && start;
        w_acc       = state == LOAD && w_valid;
        a_ready     = state == COMPUTE && issued < nv;
        issue       = a_valid && a_ready;
        busy        = state != IDLE;
        done        = state == DONE;
        w_ready     = state == LOAD;
        pe_load_en  = w_acc ? ROWS'(1) << row : '0;
        pe_compute  = state == COMPUTE || state == DRAIN;
        pe_zero_act = state == DRAIN || (state == COMPUTE && !issue);
        state_n     = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = w_acc && row == RW'(ROWS - 1) ? (nv == '0 ? DONE : COMPUTE) : LOAD;
            COMPUTE: state_n = issue && issued == nv - 1'b1 ? DRAIN : COMPUTE;
            DRAIN:   state_n = dcnt == DW'(LAT - 1) ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    // Array cannot stall, so validity simply rides alongside the data for LAT cycles.
    valid_delay_line #(.DEPTH(LAT)) u_vdl (
        .clk  (clk),
        .rst  (rst),
        .din  (issue),
        .dout (res_valid)
    );
`ifdef PE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || job_start) stall_cnt <= '0;
        else if (state == COMPUTE && !issue && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign stall_cnt = '0;
`endif
endmodule
